// File: rtl/lsu.sv
// Single-outstanding RISC-V load/store unit: decodes funct3, aligns store lanes,
// extracts and extends load data, and reports misaligned/illegal ops without touching memory.
package core_pkg;
  localparam int Xlen = 64;
endpackage

module lsu
  import core_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              store_i,
  input  logic [2:0]        funct3_i,
  input  logic [Xlen-1:0]   addr_i,
  input  logic [Xlen-1:0]   wdata_i,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic [Xlen-1:0]   mem_addr_o,
  output logic              mem_we_o,
  output logic [Xlen/8-1:0] mem_wmask_o,
  output logic [Xlen-1:0]   mem_wdata_o,
  input  logic              mem_rvalid_i,
  input  logic [Xlen-1:0]   mem_rdata_i,
  output logic              done_o,
  output logic [Xlen-1:0]   rd_data_o,
  output logic              misaligned_o,
  output logic              illegal_o
);
  localparam int Bytes = Xlen / 8;
  localparam int OffW  = $clog2(Bytes);
  localparam bit Rv64  = (Xlen == 64);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e            state_q;
  logic              ready_q, mem_valid_q, mem_we_q, done_q, mis_q, ill_q, store_q;
  logic [2:0]        f3_q;
  logic [OffW-1:0]   off_q;
  logic [Xlen-1:0]   mem_addr_q, mem_wdata_q, rd_data_q;
  logic [Bytes-1:0]  mem_wmask_q;

  logic [1:0]        sl_d;
  logic [OffW-1:0]   off_d;
  logic              legal_d, mis_d;
  logic [Bytes-1:0]  mask_d;
  logic [Xlen-1:0]   wdata_d, sh_d, rdata_d;

  always_comb begin
    sl_d  = funct3_i[1:0];
    off_d = addr_i[OffW-1:0];
    if (store_i) legal_d = (funct3_i[2] == 1'b0) && (funct3_i[1:0] != 2'd3 || Rv64);
    else begin
      case (funct3_i)
        3'd0, 3'd1, 3'd2, 3'd4, 3'd5: legal_d = 1'b1;
        3'd3, 3'd6:                   legal_d = Rv64;
        default:                      legal_d = 1'b0;
      endcase
    end
    mis_d   = (off_d & OffW'((4'd1 << sl_d) - 4'd1)) != '0;
    mask_d  = store_i ? (Bytes'((9'd1 << (4'd1 << sl_d)) - 9'd1) << off_d) : '0;
    wdata_d = wdata_i << {off_d, 3'b000};
  end

  // Load extraction uses the latched offset/funct3 since inputs are not sampled after accept.
  always_comb begin
    sh_d = mem_rdata_i >> {off_q, 3'b000};
    case (f3_q)
      3'd0:    rdata_d = Xlen'($signed(sh_d[7:0]));
      3'd1:    rdata_d = Xlen'($signed(sh_d[15:0]));
      3'd2:    rdata_d = Xlen'($signed(sh_d[31:0]));
      3'd4:    rdata_d = Xlen'(sh_d[7:0]);
      3'd5:    rdata_d = Xlen'(sh_d[15:0]);
      3'd6:    rdata_d = Xlen'(sh_d[31:0]);
      default: rdata_d = sh_d;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wmask_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      rd_data_q   <= '0;
      mis_q       <= 1'b0;
      ill_q       <= 1'b0;
      store_q     <= 1'b0;
      f3_q        <= '0;
      off_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (valid_i) begin
          store_q   <= store_i;
          f3_q      <= funct3_i;
          off_q     <= off_d;
          rd_data_q <= '0;
          ready_q   <= 1'b0;
          if (!legal_d || mis_d) begin
            ill_q   <= !legal_d;
            mis_q   <= legal_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            mem_valid_q <= 1'b1;
            mem_addr_q  <= {addr_i[Xlen-1:OffW], OffW'(0)};
            mem_we_q    <= store_i;
            mem_wmask_q <= mask_d;
            mem_wdata_q <= wdata_d;
            state_q     <= REQ;
          end
        end
        REQ: if (mem_ready_i) begin
          mem_valid_q <= 1'b0;
          mem_we_q    <= 1'b0;
          mem_wmask_q <= '0;
          if (store_q) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: if (mem_rvalid_i) begin
          rd_data_q <= rdata_d;
          done_q    <= 1'b1;
          state_q   <= DONE;
        end
        default: begin
          done_q  <= 1'b0;
          mis_q   <= 1'b0;
          ill_q   <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready_o      = ready_q;
  assign mem_valid_o  = mem_valid_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_we_o     = mem_we_q;
  assign mem_wmask_o  = mem_wmask_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign done_o       = done_q;
  assign rd_data_o    = rd_data_q;
  assign misaligned_o = mis_q;
  assign illegal_o    = ill_q;
endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameters: none; width Xlen SHALL come from core_pkg, legal values 32 or 64; Bytes = Xlen/8, OffW = log2(Bytes).
REQ-002 clk_i  input  1  single clock, all state on rising edge.
REQ-003 rst_ni  input  1  reset is synchronous and active-low.
REQ-004 valid_i  input  1  upstream execute stage presents a memory op.
REQ-005 ready_o  output  1  LSU can accept an op this cycle.
REQ-006 store_i  input  1  1 = store, 0 = load.
REQ-007 funct3_i  input  3  RISC-V load/store funct3.
REQ-008 addr_i  input  Xlen  effective address, the ALU Add result.
REQ-009 wdata_i  input  Xlen  store source (rs2), LSB-aligned.
REQ-010 mem_valid_o  output  1  memory request valid.
REQ-011 mem_ready_i  input  1  memory accepts request.
REQ-012 mem_addr_o  output  Xlen  request address, low OffW bits zero.
REQ-013 mem_we_o  output  1  write enable.
REQ-014 mem_wmask_o  output  Bytes  byte-lane write mask.
REQ-015 mem_wdata_o  output  Xlen  lane-shifted store data.
REQ-016 mem_rvalid_i  input  1  read response valid.
REQ-017 mem_rdata_i  input  Xlen  read response, full aligned word.
REQ-018 done_o  output  1  one-cycle completion pulse.
REQ-019 rd_data_o  output  Xlen  load result, valid while done_o=1.
REQ-020 misaligned_o  output  1  address misaligned, valid while done_o=1.
REQ-021 illegal_o  output  1  unsupported funct3, valid while done_o=1.

Function
REQ-022 FSM states SHALL be IDLE, REQ, WAIT, DONE; ready_o=1 only in IDLE.
REQ-023 Accept when valid_i && ready_o: latch store_i, funct3_i, addr_i, wdata_i; no other input is sampled until the next IDLE.
REQ-024 Supported funct3: loads 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; 3 LD and 6 LWU only when Xlen=64; stores 0 SB, 1 SH, 2 SW; 3 SD only when Xlen=64; all others illegal.
REQ-025 Access size 1/2/4/8 bytes from funct3[1:0]; misaligned when addr mod size != 0.
REQ-026 On accept of an illegal or misaligned op: IDLE->DONE, no memory request; illegal_o takes priority over misaligned_o, and only one is set.
REQ-027 On accept of a legal aligned op: IDLE->REQ.
REQ-028 In REQ: mem_valid_o=1; mem_addr_o = addr with low OffW bits cleared; mem_we_o=store; mem_addr_o, mem_we_o, mem_wmask_o and mem_wdata_o held stable until mem_ready_i=1.
REQ-029 REQ with mem_ready_i=1: store->DONE, load->WAIT; mem_valid_o drops next cycle.
REQ-030 Store lanes: off = addr[OffW-1:0]; mem_wmask_o = ((1<<size)-1)<<off; mem_wdata_o = wdata_i<<(8*off), with unused lanes don't-care; loads drive mem_wmask_o=0.
REQ-031 In WAIT, mem_rvalid_i=1 captures (mem_rdata_i>>(8*off)), truncated to size and sign- (LB/LH/LW/LD) or zero- (LBU/LHU/LWU) extended to Xlen; state moves to DONE.
REQ-032 mem_rvalid_i outside WAIT SHALL be ignored.
REQ-033 DONE lasts exactly one cycle: done_o=1, then IDLE; rd_data_o=0 for stores and faults.
REQ-034 Minimum latency, accept edge to done_o: store 2 cycles, load 3 cycles, fault 1 cycle; each memory stall adds one cycle.
REQ-035 Only one op is ever outstanding; valid_i during REQ/WAIT/DONE SHALL NOT be accepted.

Reset
REQ-036 rst_ni=0 at a clock edge forces IDLE from any state, including mid-REQ or mid-WAIT; the in-flight op is dropped.
REQ-037 After reset: ready_o=1; mem_valid_o, mem_we_o, mem_wmask_o, done_o, misaligned_o, illegal_o = 0; mem_addr_o, mem_wdata_o, rd_data_o = 0.
REQ-038 A late mem_rvalid_i for a dropped op SHALL be ignored and SHALL NOT produce done_o.

Verification (Xlen=64)
REQ-039 LB, addr 0x1003, mem_rdata 0x0000_0000_8000_0000 -> mem_addr_o 0x1000; done_o with rd_data_o 0xFFFF_FFFF_FFFF_FF80; LBU of the same gives 0x80.
REQ-040 SH, addr 0x1006, wdata 0x1234 -> mem_we_o=1, mem_wmask_o 0xC0, mem_wdata_o[63:48]=0x1234; done_o 2 cycles after accept with mem_ready_i=1.
REQ-041 LW, addr 0x1002 -> mem_valid_o never asserted; done_o the next cycle with misaligned_o=1; funct3=7 -> illegal_o=1.
REQ-042 mem_ready_i low for 5 cycles in REQ -> mem_valid_o, mem_addr_o and mem_wdata_o stable for all 6 cycles; ready_o=0 throughout; valid_i pulses ignored.
REQ-043 rst_ni=0 for one cycle while in WAIT -> IDLE, ready_o=1, mem_valid_o=0; mem_rvalid_i two cycles later produces no done_o.
REQ-044 Back-to-back ops with valid_i held high -> second op accepted in the cycle after the first op's done_o, never in the same cycle.
